// File: rtl/p_tree_pkg.sv
// Shared types for the P-packet tree upstream merge channel.
package p_tree_pkg;

  localparam int P_DATA_WIDTH = 16;

  typedef enum logic [1:0] {IDLE, WAIT_DATA, SEND} merge_state_t;

  typedef enum logic {SRC_C1 = 1'b0, SRC_C2 = 1'b1} p_src_t;

endpackage

// File: rtl/p_merge_tx_if.sv
// Token channels between two children, the merge block and its parent.
interface p_merge_tx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic                  c1_req_valid;
  logic                  c1_req_ready;
  logic                  c1_data_valid;
  logic [DATA_WIDTH-1:0] c1_data;
  logic                  c1_data_ready;
  logic                  c2_req_valid;
  logic                  c2_req_ready;
  logic                  c2_data_valid;
  logic [DATA_WIDTH-1:0] c2_data;
  logic                  c2_data_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_src;
  logic                  out_ready;
  logic [CNT_WIDTH-1:0]  c1_pkt_cnt;
  logic [CNT_WIDTH-1:0]  c2_pkt_cnt;

  // Environment side: drives child tokens and parent ready.
  modport master (
    output c1_req_valid, c1_data_valid, c1_data,
    output c2_req_valid, c2_data_valid, c2_data,
    output out_ready,
    input  c1_req_ready, c1_data_ready, c2_req_ready, c2_data_ready,
    input  out_valid, out_data, out_src, c1_pkt_cnt, c2_pkt_cnt
  );

  // Merge block side.
  modport slave (
    input  c1_req_valid, c1_data_valid, c1_data,
    input  c2_req_valid, c2_data_valid, c2_data,
    input  out_ready,
    output c1_req_ready, c1_data_ready, c2_req_ready, c2_data_ready,
    output out_valid, out_data, out_src, c1_pkt_cnt, c2_pkt_cnt
  );
endinterface

// File: rtl/p_merge_tx_rr_arb2.sv
// Two-input round-robin arbiter; the last-grant history is held by the caller.
module rr_arb2
  import p_tree_pkg::*;
(
  input  logic [1:0] req,
  input  p_src_t     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    // Contested: favour whichever child did not win last time.
    if (req == 2'b11) begin
      grant = (last_grant == SRC_C1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/p_merge_tx.sv
// Merges req+data packets from two children onto one parent channel, tagged by source.
// Define MERGE_STATS_EN to enable the saturating per-child packet counters.
module p_merge_tx
  import p_tree_pkg::*;
#(
  parameter int DATA_WIDTH = P_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         reset,
  p_merge_tx_if.slave  bus
);

  merge_state_t          state_q, state_d;
  p_src_t                grant_q, grant_d;
  p_src_t                last_q, last_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  p_src_t                out_src_q, out_src_d;

  logic [1:0]            arb_gnt;
  logic                  req_xfer, data_xfer, out_xfer;
  logic                  sel_data_valid;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arb2 u_arb (
    .req        ({bus.c2_req_valid, bus.c1_req_valid}),
    .last_grant (last_q),
    .grant      (arb_gnt)
  );

  // Readies are gated by reset so nothing is accepted while it is asserted.
  assign bus.c1_req_ready  = !reset && (state_q == IDLE) && arb_gnt[0];
  assign bus.c2_req_ready  = !reset && (state_q == IDLE) && arb_gnt[1];
  assign bus.c1_data_ready = !reset && (state_q == WAIT_DATA) && (grant_q == SRC_C1);
  assign bus.c2_data_ready = !reset && (state_q == WAIT_DATA) && (grant_q == SRC_C2);

  assign sel_data_valid = (grant_q == SRC_C2) ? bus.c2_data_valid : bus.c1_data_valid;
  assign sel_data       = (grant_q == SRC_C2) ? bus.c2_data       : bus.c1_data;

  assign req_xfer  = (bus.c1_req_valid && bus.c1_req_ready) ||
                     (bus.c2_req_valid && bus.c2_req_ready);
  assign data_xfer = (state_q == WAIT_DATA) && sel_data_valid && !reset;
  assign out_xfer  = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    case (state_q)
      IDLE: begin
        if (req_xfer) begin
          grant_d = arb_gnt[1] ? SRC_C2 : SRC_C1;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (data_xfer) begin
          out_data_d  = sel_data;
          out_src_d   = grant_q;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        // out_data is deliberately left holding the last packet.
        if (out_xfer) begin
          out_valid_d = 1'b0;
          last_d      = grant_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= SRC_C1;
      last_q      <= SRC_C2;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= SRC_C1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

`ifdef MERGE_STATS_EN
  logic [CNT_WIDTH-1:0] c1_cnt_q, c1_cnt_d;
  logic [CNT_WIDTH-1:0] c2_cnt_q, c2_cnt_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    c1_cnt_d = c1_cnt_q;
    c2_cnt_d = c2_cnt_q;
    if (out_xfer && (out_src_q == SRC_C1)) c1_cnt_d = sat_inc(c1_cnt_q);
    if (out_xfer && (out_src_q == SRC_C2)) c2_cnt_d = sat_inc(c2_cnt_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c1_cnt_q <= '0;
      c2_cnt_q <= '0;
    end else begin
      c1_cnt_q <= c1_cnt_d;
      c2_cnt_q <= c2_cnt_d;
    end
  end

  assign bus.c1_pkt_cnt = c1_cnt_q;
  assign bus.c2_pkt_cnt = c2_cnt_q;
`else
  assign bus.c1_pkt_cnt = '0;
  assign bus.c2_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_p_merge_tx.sv
// Directed bench for p_merge_tx; a second narrow-counter instance shadows the same stimulus.
module tb_p_merge_tx;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  p_merge_tx_if #(.DATA_WIDTH(16), .CNT_WIDTH(16)) ifc ();
  p_merge_tx_if #(.DATA_WIDTH(16), .CNT_WIDTH(2))  ifc2 ();

  p_merge_tx #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(ifc));
  p_merge_tx #(.DATA_WIDTH(16), .CNT_WIDTH(2))  dut2 (.clk(clk), .reset(reset), .bus(ifc2));

  assign ifc2.c1_req_valid  = ifc.c1_req_valid;
  assign ifc2.c1_data_valid = ifc.c1_data_valid;
  assign ifc2.c1_data       = ifc.c1_data;
  assign ifc2.c2_req_valid  = ifc.c2_req_valid;
  assign ifc2.c2_data_valid = ifc.c2_data_valid;
  assign ifc2.c2_data       = ifc.c2_data;
  assign ifc2.out_ready     = ifc.out_ready;

`ifdef MERGE_STATS_EN
  localparam int EXP_C1 = 5, EXP_C2 = 3, EXP_S1 = 3, EXP_S2 = 3;
`else
  localparam int EXP_C1 = 0, EXP_C2 = 0, EXP_S1 = 0, EXP_S2 = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ifc.c1_req_valid  = 1'b0;
    ifc.c1_data_valid = 1'b0;
    ifc.c2_req_valid  = 1'b0;
    ifc.c2_data_valid = 1'b0;
  endtask

  function automatic logic [3:0] readies();
    return {ifc.c1_req_ready, ifc.c1_data_ready, ifc.c2_req_ready, ifc.c2_data_ready};
  endfunction

  // Uncontested packet from one child with the parent always ready.
  task automatic send_pkt(input bit src, input logic [15:0] d, input string tag);
    @(negedge clk);
    ifc.out_ready = 1'b1;
    if (src) ifc.c2_req_valid = 1'b1; else ifc.c1_req_valid = 1'b1;
    #1 chk({tag, ".req_rdy"}, src ? ifc.c2_req_ready : ifc.c1_req_ready, 1);
    @(negedge clk);
    clear_inputs();
    if (src) begin ifc.c2_data_valid = 1'b1; ifc.c2_data = d; end
    else     begin ifc.c1_data_valid = 1'b1; ifc.c1_data = d; end
    #1 chk({tag, ".data_rdy"}, src ? ifc.c2_data_ready : ifc.c1_data_ready, 1);
    chk({tag, ".early_vld"}, ifc.out_valid, 0);
    @(negedge clk);
    clear_inputs();
    #1 chk({tag, ".out_vld"}, ifc.out_valid, 1);
    chk({tag, ".out_data"}, ifc.out_data, d);
    chk({tag, ".out_src"}, ifc.out_src, src);
    @(negedge clk);
    #1 chk({tag, ".vld_clr"}, ifc.out_valid, 0);
    chk({tag, ".held"}, ifc.out_data, d);
  endtask

  initial begin
    int n;
    logic [16:0] got [4];

    reset = 1'b1;
    clear_inputs();
    ifc.c1_data   = '0;
    ifc.c2_data   = '0;
    ifc.out_ready = 1'b0;

    // Reset values, with a req offered to confirm ready stays low.
    @(negedge clk);
    ifc.c1_req_valid = 1'b1;
    #1 chk("rst.c1_req_rdy", ifc.c1_req_ready, 0);
    chk("rst.readies", readies(), 4'b0000);
    chk("rst.out_valid", ifc.out_valid, 0);
    chk("rst.out_data", ifc.out_data, 0);
    chk("rst.out_src", ifc.out_src, 0);
    chk("rst.c1_cnt", ifc.c1_pkt_cnt, 0);
    chk("rst.c2_cnt", ifc.c2_pkt_cnt, 0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;

    send_pkt(1'b0, 16'hA5C3, "single");

    // Contested pairs from a fresh reset: C1 first, then alternation.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    ifc.c1_req_valid = 1'b1; ifc.c1_data_valid = 1'b1; ifc.c1_data = 16'h1111;
    ifc.c2_req_valid = 1'b1; ifc.c2_data_valid = 1'b1; ifc.c2_data = 16'h2222;
    ifc.out_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
      @(negedge clk);
      #1;
      if (ifc.out_valid) begin
        got[n] = {ifc.out_src, ifc.out_data};
        n++;
      end
    end
    clear_inputs();
    chk("rr.count", n, 4);
    chk("rr.pkt0", got[0], {1'b0, 16'h1111});
    chk("rr.pkt1", got[1], {1'b1, 16'h2222});
    chk("rr.pkt2", got[2], {1'b0, 16'h1111});
    chk("rr.pkt3", got[3], {1'b1, 16'h2222});
    @(negedge clk);
    #1 chk("rr.idle", ifc.out_valid, 0);

    // Backpressure: parent stalls for 10 cycles in SEND.
    ifc.c1_req_valid = 1'b1; ifc.c1_data_valid = 1'b1; ifc.c1_data = 16'h3C3C;
    ifc.c2_req_valid = 1'b1; ifc.c2_data_valid = 1'b1; ifc.c2_data = 16'h4D4D;
    ifc.out_ready = 1'b0;
    #1 chk("bp.req_rdy", readies(), 4'b1000);
    @(negedge clk);
    #1 chk("bp.data_rdy", readies(), 4'b0100);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 chk("bp.hold_vld", ifc.out_valid, 1);
      chk("bp.hold_data", ifc.out_data, 16'h3C3C);
      chk("bp.no_ready", readies(), 4'b0000);
      @(negedge clk);
    end
    ifc.out_ready = 1'b1;
    clear_inputs();
    #1 chk("bp.release_vld", ifc.out_valid, 1);
    @(negedge clk);
    #1 chk("bp.one_xfer", ifc.out_valid, 0);
    chk("bp.src", ifc.out_src, 0);
    @(negedge clk);
    #1 chk("bp.stays_idle", ifc.out_valid, 0);

    // Data offered without its req is never accepted.
    ifc.c2_data_valid = 1'b1; ifc.c2_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1 chk("norq.data_rdy", ifc.c2_data_ready, 0);
      chk("norq.out_vld", ifc.out_valid, 0);
      @(negedge clk);
    end
    clear_inputs();

    // Reset while waiting for data discards the packet.
    ifc.c1_req_valid = 1'b1;
    #1 chk("rstw.req_rdy", ifc.c1_req_ready, 1);
    @(negedge clk);
    clear_inputs();
    ifc.c1_data_valid = 1'b1; ifc.c1_data = 16'hDEAD;
    #1 chk("rstw.data_rdy", ifc.c1_data_ready, 1);
    #1 reset = 1'b1;
    #1 chk("rstw.data_rdy_rst", ifc.c1_data_ready, 0);
    chk("rstw.out_vld", ifc.out_valid, 0);
    chk("rstw.out_data", ifc.out_data, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rstw.no_data_rdy", ifc.c1_data_ready, 0);
    @(negedge clk);
    #1 chk("rstw.not_emitted", ifc.out_valid, 0);
    clear_inputs();
    ifc.c1_req_valid = 1'b1; ifc.c2_req_valid = 1'b1;
    #1 chk("rstw.c1_wins", readies(), 4'b1000);
    clear_inputs();

    // Packet counters from a clean reset.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    send_pkt(1'b0, 16'h0101, "st.c1a");
    send_pkt(1'b1, 16'h0202, "st.c2a");
    send_pkt(1'b0, 16'h0303, "st.c1b");
    send_pkt(1'b0, 16'h0404, "st.c1c");
    send_pkt(1'b1, 16'h0505, "st.c2b");
    send_pkt(1'b0, 16'h0606, "st.c1d");
    send_pkt(1'b1, 16'h0707, "st.c2c");
    send_pkt(1'b0, 16'h0808, "st.c1e");
    chk("st.c1_cnt", ifc.c1_pkt_cnt, EXP_C1);
    chk("st.c2_cnt", ifc.c2_pkt_cnt, EXP_C2);
    chk("st.c1_sat", ifc2.c1_pkt_cnt, EXP_S1);
    chk("st.c2_sat", ifc2.c2_pkt_cnt, EXP_S2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
